// File: rtl/mod7_pkg.sv
// Shared constants for the mod-7 down counter.
// Digit lives in [2:0], the wrap/borrow count in [7:3].
package mod7_pkg;

    localparam int         MOD7          = 7;
    localparam logic [2:0] DIGIT_MAX     = 3'd6;
    localparam logic [2:0] DIGIT_ILLEGAL = 3'd7;
    localparam logic [7:0] Q_RESET       = 8'h06;
    localparam int         WRAP_W        = 5;

    function automatic logic digit_illegal(input logic [2:0] d);
        return d == DIGIT_ILLEGAL;
    endfunction

endpackage

// File: rtl/dff_sync_r.sv
// D flip-flop with true/complement outputs.
// Synchronous active-high reset to RST_VAL.
module dff_sync_r #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic qb_o
);

    logic bit_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) bit_q <= RST_VAL;
        else       bit_q <= d_i;
    end

    assign q_o  = bit_q;
    assign qb_o = ~bit_q;

endmodule

// File: rtl/mod7_down_counter_8bit.sv
// Mod-7 down counter with 5-bit wrap field.
// Gate-level digit logic, sticky illegal-digit flag.
module mod7_down_counter_8bit
    import mod7_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] Q,
    output logic       tc,
    output logic       err
);

    logic [7:0]        state_q;
    logic [7:0]        state_qb;
    logic [7:0]        state_d;
    logic              err_q;
    logic              err_qb;
    logic              err_d;
    logic [2:0]        dig_dec;
    logic [2:0]        lv_digit;
    logic [WRAP_W-1:0] wrap_dec;
    logic [WRAP_W-1:0] brw;
    logic              dig_zero;
    logic              dig_ill;
    logic              lv_ill;
    logic              err_set;

    assign dig_zero = state_qb[2] & state_qb[1] & state_qb[0];
    assign dig_ill  = state_q[2] & state_q[1] & state_q[0];

    // 7 decodes to 6 with no borrow, same as the 0 -> 6 code path minus borrow
    always_comb begin
        dig_dec[0] = state_qb[0] & (state_q[1] | state_q[2]);
        dig_dec[1] = (state_q[1] & state_q[0])
                   | (state_qb[1] & state_qb[0]);
        dig_dec[2] = (state_q[2] & state_q[0])
                   | (state_q[2] & state_q[1])
                   | (state_qb[2] & state_qb[1] & state_qb[0]);
    end

    always_comb begin
        brw    = '0;
        brw[0] = dig_zero;
        for (int i = 1; i < WRAP_W; i++) begin
            brw[i] = brw[i-1] & state_qb[2+i];
        end
        for (int i = 0; i < WRAP_W; i++) begin
            wrap_dec[i] = state_q[3+i] ^ brw[i];
        end
    end

    assign lv_ill   = digit_illegal(load_val[2:0]);
    assign lv_digit = lv_ill ? DIGIT_MAX : load_val[2:0];

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (load) begin
            state_d = {load_val[7:3], lv_digit};
            err_set = lv_ill;
        end else if (en) begin
            state_d = {wrap_dec, dig_dec};
            err_set = dig_ill;
        end
    end

    assign err_d = ~err_qb | err_set;

    for (genvar i = 0; i < 8; i++) begin : g_state
        dff_sync_r #(
            .RST_VAL(Q_RESET[i])
        ) u_bit (
            .clk_i(clk),
            .rst_i(reset),
            .d_i  (state_d[i]),
            .q_o  (state_q[i]),
            .qb_o (state_qb[i])
        );
    end

    dff_sync_r #(
        .RST_VAL(1'b0)
    ) u_err (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (err_d),
        .q_o  (err_q),
        .qb_o (err_qb)
    );

    assign Q   = state_q;
    assign err = err_q;
    assign tc  = en & ~load & (state_q == 8'h00);

endmodule

// File: tb/tb_mod7_down_counter_8bit.sv
// Scoreboard bench for the mod-7 down counter.
// Driver queues expectations; monitor checks after each edge.
module tb_mod7_down_counter_8bit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] Q;
    logic       tc;
    logic       err;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic       err;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   tc_cnt = 0;

    mod7_down_counter_8bit dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .Q       (Q),
        .tc      (tc),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Inputs are held from negedge to negedge, so tc seen here
    // reflects the post-edge Q with this cycle's inputs.
    always @(posedge clk) begin
        #2;
        if (tc === 1'b1) tc_cnt++;
        if (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            total++;
            if (Q !== it.q || tc !== it.tc || err !== it.err) begin
                bad++;
                $display("FAIL %s: got Q=%h tc=%b err=%b want Q=%h tc=%b err=%b",
                         it.nm, Q, tc, err, it.q, it.tc, it.err);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [7:0] lv, input logic [7:0] wq,
                        input logic werr, input string nm);
        exp_t it;
        @(negedge clk);
        reset    = r;
        en       = e;
        load     = l;
        load_val = lv;
        it.q   = wq;
        it.tc  = e & ~l & (wq == 8'h00);
        it.err = werr;
        it.nm  = nm;
        sb.push_back(it);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [7:0] dec(input logic [7:0] q);
        if (q[2:0] == 3'd0) return {q[7:3] - 5'd1, 3'd6};
        return q - 8'd1;
    endfunction

    logic [7:0] seq8 [8] = '{8'h05, 8'h04, 8'h03, 8'h02,
                             8'h01, 8'h00, 8'hFE, 8'hFD};
    logic [7:0] m;

    initial begin
        step(1, 0, 0, 8'h00, 8'h06, 0, "reset");
        step(1, 1, 0, 8'h00, 8'h06, 0, "reset_en_held");

        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 8'h00, seq8[i], 0, "count8");

        step(1, 0, 0, 8'h00, 8'h06, 0, "reset224");
        m = 8'h06;
        drain();
        tc_cnt = 0;
        for (int i = 0; i < 224; i++) begin
            m = dec(m);
            step(0, 1, 0, 8'h00, m, 0, "run224");
        end
        step(0, 0, 0, 8'h00, 8'h06, 0, "run224_end");
        drain();
        total++;
        if (tc_cnt != 1) begin
            bad++;
            $display("FAIL tc_pulses: got %0d want 1", tc_cnt);
        end

        step(0, 1, 1, 8'h1B, 8'h1B, 0, "load_prio");
        step(0, 1, 0, 8'h00, 8'h1A, 0, "after_load");
        step(0, 0, 0, 8'h00, 8'h1A, 0, "hold");

        step(0, 0, 1, 8'h0F, 8'h0E, 1, "load_ill");
        m = 8'h0E;
        for (int i = 0; i < 50; i++) begin
            m = dec(m);
            step(0, 1, 0, 8'h00, m, 1, "err_sticky");
        end
        step(1, 0, 0, 8'h00, 8'h06, 0, "err_clear");

        step(0, 0, 1, 8'h00, 8'h00, 0, "load_zero");
        step(1, 1, 0, 8'h00, 8'h06, 0, "reset_beats_en");
        step(0, 0, 1, 8'h00, 8'h00, 0, "load_zero2");
        step(1, 0, 1, 8'h1B, 8'h06, 0, "reset_beats_load");

        step(0, 1, 0, 8'h00, 8'h05, 0, "mid_a");
        step(0, 1, 0, 8'h00, 8'h04, 0, "mid_b");
        step(1, 1, 0, 8'h00, 8'h06, 0, "mid_reset");
        step(0, 1, 0, 8'h00, 8'h05, 0, "post_reset");

        step(0, 0, 1, 8'h03, 8'h03, 0, "load3");
        step(0, 1, 0, 8'h00, 8'h02, 0, "tog1");
        step(0, 0, 0, 8'h00, 8'h02, 0, "tog0a");
        step(0, 0, 0, 8'h00, 8'h02, 0, "tog0b");
        step(0, 1, 0, 8'h00, 8'h01, 0, "tog1b");

        step(0, 0, 1, 8'h01, 8'h01, 0, "load1");
        step(0, 1, 0, 8'h00, 8'h00, 0, "tc_hit");
        step(0, 1, 1, 8'h00, 8'h00, 0, "tc_load_mask");
        step(0, 0, 0, 8'h00, 8'h00, 0, "tc_en_low");
        step(0, 1, 0, 8'h00, 8'hFE, 0, "wrap_under");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/mod7_down_counter_8bit.md
MOD7_DOWN_COUNTER_8BIT -- requirements
Module: mod7_down_counter_8bit

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL expose `en`, input, 1 bit: count enable; decrement by one when high.
REQ-004 The block SHALL expose `load`, input, 1 bit: parallel load strobe.
REQ-005 The block SHALL expose `load_val`, input, 8 bits: load value; [2:0] is the digit, [7:3] is the wrap field.
REQ-006 The block SHALL expose `Q`, output, 8 bits: count state; Q[2:0] is the mod-7 digit (0..6), Q[7:3] is the borrow/wrap count.
REQ-007 The block SHALL expose `tc`, output, 1 bit: terminal count, combinational, equal to en & ~load & (Q == 8'h00).
REQ-008 The block SHALL expose `err`, output, 1 bit: sticky illegal-digit flag.

Function
REQ-009 The digit SHALL count down 6,5,4,3,2,1,0,6 when en=1 and load=0, with exactly one step per enabled clock.
REQ-010 The digit SHALL produce a borrow on the 0->6 transition, and the wrap field Q[7:3] SHALL decrement by one on the same edge, modulo 32 (5'd0 -> 5'd31).
REQ-011 The full sequence period SHALL be 224 enabled clocks: 8'h06 ... 8'h00 -> 8'hFE (wrap 31, digit 6).
REQ-012 When en=0 and load=0, Q SHALL hold its value.
REQ-013 load SHALL take priority over en: Q <= load_val on the next edge, with no decrement in that cycle and tc=0.
REQ-014 If load_val[2:0] == 3'd7, the loaded digit SHALL be clamped to 3'd6, the wrap field SHALL load load_val[7:3] unchanged, and err SHALL be set on the same edge.
REQ-015 If the digit state ever reads 3'd7 (SEU or X-recovery) with en=1, the next digit SHALL be 3'd6 with no borrow, and err SHALL be set.
REQ-016 Once set, err SHALL remain 1 until reset.
REQ-017 Latency: a change on en or load SHALL be visible on Q exactly one clock later; tc SHALL have zero latency (combinational).
REQ-018 Simultaneous reset and load or en SHALL be resolved in favour of reset.

Reset
REQ-019 On a reset edge, Q SHALL be set to 8'h06 (wrap 0, digit 6) and err to 0.
REQ-020 With reset held, tc SHALL be 0 regardless of en, because Q != 0.
REQ-021 Reset asserted mid-count SHALL abandon the count; the first enabled edge after release SHALL yield 8'h05.
REQ-022 No asynchronous reset path SHALL exist.

Structure
REQ-023 Package `mod7_pkg` SHALL hold the following constants: MOD7 = 7, DIGIT_MAX = 3'd6, DIGIT_ILLEGAL = 3'd7, Q_RESET = 8'h06, WRAP_W = 5.
REQ-024 The digit next-state logic SHALL be sum-of-products gates on Q/Qb, in the same style as the up counter.
REQ-025 The wrap field SHALL be a 5-bit borrow-ripple decrementer gated by the digit borrow.
REQ-026 All 8 state bits plus err SHALL be instances of one sub-module, `dff_sync_r`: a D flip-flop with Q/Qb outputs and synchronous active-high reset.

Verification
REQ-027 Reset, then en=1 for 8 clocks -> Q = 05,04,03,02,01,00,FE,FD; tc=1 only in the cycle where Q=00.
REQ-028 After reset, en=1 for 224 clocks -> Q returns to 8'h06; tc pulses exactly once; err=0 throughout.
REQ-029 load=1, en=1, load_val=8'h1B (digit 3, wrap 3) -> next Q = 8'h1B, not decremented; next enabled edge -> 8'h1A.
REQ-030 load_val=8'h0F (digit 7) with load=1 -> Q = 8'h0E and err=1; err stays 1 over 50 further clocks until reset clears it.
REQ-031 en=1 at Q=8'h00 with reset=1 on the same edge -> Q = 8'h06, not 8'hFE; err=0.
REQ-032 en toggled 1,0,0,1 starting from 8'h03 -> Q = 02,02,02,01; tc=0 throughout.
